lsync_peak_ctrl: RTL and testbench

- Sequences the long-preamble correlator. On a start pulse from short sync, it clears the correlator, enables it and scores each correlator output with the metric |I|+|Q|.
- It finds the first long-training peak, refines it, then confirms a second peak 64 samples later.
- It reports the lock index to the FFT/symbol-timing stage, or reports failure on timeout.
- It sits between the correlator and the receiver front-end timing logic.

---
 rtl/lsync_pkg.sv | 23 ++
 rtl/lsync_metric.sv | 25 ++
 rtl/lsync_peak_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lsync_peak_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsync_pkg.sv
// Shared definitions for the long-preamble sync controller and its metric scorer.
package lsync_pkg;

   // Correlator output width and the scorer's result width (|I|+|Q| up to 128).
   localparam int unsigned CORR_W     = 7;
   localparam int unsigned METRIC_W   = 8;

   localparam logic [7:0]  THRESH_DEF = 8'd40;
   localparam int unsigned PERIOD_DEF = 64;
   localparam int unsigned CW_DEF     = 10;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StClear   = 3'd1,
      StSearch  = 3'd2,
      StRefine  = 3'd3,
      StWait2   = 3'd4,
      StSearch2 = 3'd5,
      StLocked  = 3'd6,
      StFail    = 3'd7
   } lsync_state_t;

endpackage

// File: rtl/lsync_metric.sv
// Combinational |I|+|Q| scorer; inputs are widened before negation so -64 maps to +64.
module lsync_metric
   import lsync_pkg::*;
(
   input  logic signed [CORR_W-1:0] i_i_corr,
   input  logic signed [CORR_W-1:0] i_q_corr,
   output logic [METRIC_W-1:0]      o_metric
);

   logic [METRIC_W-1:0] w_i_ext;
   logic [METRIC_W-1:0] w_q_ext;
   logic [METRIC_W-1:0] w_i_abs;
   logic [METRIC_W-1:0] w_q_abs;

   assign w_i_ext = {{(METRIC_W-CORR_W){i_i_corr[CORR_W-1]}}, i_i_corr};
   assign w_q_ext = {{(METRIC_W-CORR_W){i_q_corr[CORR_W-1]}}, i_q_corr};

   // Two's-complement magnitude at the wider width.
   always_comb begin
      w_i_abs  = w_i_ext[METRIC_W-1] ? (~w_i_ext + METRIC_W'(1)) : w_i_ext;
      w_q_abs  = w_q_ext[METRIC_W-1] ? (~w_q_ext + METRIC_W'(1)) : w_q_ext;
      o_metric = w_i_abs + w_q_abs;
   end

endmodule

// File: rtl/lsync_peak_ctrl.sv
// Long-preamble peak controller: finds and refines peak 1, confirms peak 2 one period later.
// Assumes REFINE_LEN >= 1 and TOL >= 1.
module lsync_peak_ctrl
   import lsync_pkg::*;
#(
   parameter logic [7:0]  THRESH     = THRESH_DEF,
   parameter int unsigned REFINE_LEN = 4,
   parameter int unsigned PERIOD     = PERIOD_DEF,
   parameter int unsigned TOL        = 2,
   parameter int unsigned MAX_WAIT   = 320,
   parameter int unsigned CW         = CW_DEF
) (
   input  logic                     CLK,
   input  logic                     RST_n,
   input  logic                     sync_start,
   input  logic                     corr_strobe,
   input  logic signed [CORR_W-1:0] I_corr,
   input  logic signed [CORR_W-1:0] Q_corr,
   output logic                     corr_enable,
   output logic                     corr_s_rst,
   output logic                     lock,
   output logic                     lock_strobe,
   output logic                     fail,
   output logic [CW-1:0]            peak_idx,
   output logic                     busy
);

   localparam int unsigned RW = $clog2(REFINE_LEN + 1);
   localparam int unsigned WW = $clog2(2 * TOL + 1);

   localparam logic [CW-1:0] WIN_OFS     = CW'(PERIOD - TOL);
   localparam logic [CW-1:0] LAST_SEARCH = CW'(MAX_WAIT - 1);
   localparam logic [RW-1:0] REF_LOAD    = RW'(REFINE_LEN);
   // The WAIT2 strobe is the first window sample, so SEARCH2 sees 2*TOL more.
   localparam logic [WW-1:0] WIN_LOAD    = WW'(2 * TOL);

   lsync_state_t        r_state,      w_state_nxt;
   logic [CW-1:0]       r_sample_cnt, w_cnt_nxt;
   logic [7:0]          r_max1,       w_max1_nxt;
   logic [CW-1:0]       r_idx1,       w_idx1_nxt;
   logic [7:0]          r_max2,       w_max2_nxt;
   logic [CW-1:0]       r_idx2,       w_idx2_nxt;
   logic [RW-1:0]       r_ref_cnt,    w_ref_nxt;
   logic [WW-1:0]       r_win_cnt,    w_win_nxt;
   logic                r_lock,       w_lock_nxt;
   logic                r_lock_strobe, w_lock_strobe_nxt;
   logic                r_fail,       w_fail_nxt;
   logic [CW-1:0]       r_peak_idx,   w_peak_idx_nxt;

   logic [METRIC_W-1:0] w_metric;
   logic                w_strobe;
   logic [CW-1:0]       w_cnt_inc;
   logic [CW-1:0]       w_win_start;
   logic [7:0]          w_max2_base;
   logic                w_take2;
   logic [7:0]          w_max2_new;
   logic [CW-1:0]       w_idx2_new;

   lsync_metric u_metric (
      .i_i_corr (I_corr),
      .i_q_corr (Q_corr),
      .o_metric (w_metric)
   );

   assign corr_enable = (r_state == StSearch) || (r_state == StRefine) ||
                        (r_state == StWait2)  || (r_state == StSearch2);
   assign corr_s_rst  = (r_state == StClear);
   assign busy        = (r_state != StIdle) && (r_state != StLocked) && (r_state != StFail);
   assign lock        = r_lock;
   assign lock_strobe = r_lock_strobe;
   assign fail        = r_fail;
   assign peak_idx    = r_peak_idx;

   assign w_strobe    = corr_strobe & corr_enable;
   assign w_cnt_inc   = (&r_sample_cnt) ? r_sample_cnt : r_sample_cnt + CW'(1);
   assign w_win_start = r_idx1 + WIN_OFS;

   // Peak-2 candidate: the window opens with max2 cleared, later samples need a strict increase.
   always_comb begin
      w_max2_base = (r_state == StWait2) ? 8'd0 : r_max2;
      w_take2     = (w_metric >= THRESH) && (w_metric > w_max2_base);
      w_max2_new  = w_take2 ? w_metric : w_max2_base;
      w_idx2_new  = w_take2 ? r_sample_cnt : r_idx2;
   end

   // Next-state and datapath update; sync_start overrides everything else.
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_sample_cnt;
      w_max1_nxt        = r_max1;
      w_idx1_nxt        = r_idx1;
      w_max2_nxt        = r_max2;
      w_idx2_nxt        = r_idx2;
      w_ref_nxt         = r_ref_cnt;
      w_win_nxt         = r_win_cnt;
      w_lock_nxt        = r_lock;
      w_lock_strobe_nxt = 1'b0;
      w_fail_nxt        = r_fail;
      w_peak_idx_nxt    = r_peak_idx;

      if (sync_start) begin
         w_state_nxt    = StClear;
         w_lock_nxt     = 1'b0;
         w_fail_nxt     = 1'b0;
         w_peak_idx_nxt = '0;
         w_max1_nxt     = '0;
         w_max2_nxt     = '0;
         w_idx1_nxt     = '0;
         w_idx2_nxt     = '0;
      end else begin
         case (r_state)
            StClear: begin
               w_cnt_nxt   = '0;
               w_ref_nxt   = '0;
               w_win_nxt   = '0;
               w_state_nxt = StSearch;
            end
            StSearch: begin
               if (w_strobe) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_metric >= THRESH) begin
                     w_max1_nxt  = w_metric;
                     w_idx1_nxt  = r_sample_cnt;
                     w_ref_nxt   = REF_LOAD;
                     w_state_nxt = StRefine;
                  end else if (r_sample_cnt == LAST_SEARCH) begin
                     w_fail_nxt  = 1'b1;
                     w_state_nxt = StFail;
                  end
               end
            end
            StRefine: begin
               if (w_strobe) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_metric > r_max1) begin
                     w_max1_nxt = w_metric;
                     w_idx1_nxt = r_sample_cnt;
                  end
                  w_ref_nxt = r_ref_cnt - RW'(1);
                  if (r_ref_cnt == RW'(1)) begin
                     w_state_nxt = StWait2;
                  end
               end
            end
            StWait2: begin
               if (w_strobe) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (r_sample_cnt == w_win_start) begin
                     w_max2_nxt  = w_max2_new;
                     w_idx2_nxt  = w_idx2_new;
                     w_win_nxt   = WIN_LOAD;
                     w_state_nxt = StSearch2;
                  end
               end
            end
            StSearch2: begin
               if (w_strobe) begin
                  w_cnt_nxt  = w_cnt_inc;
                  w_max2_nxt = w_max2_new;
                  w_idx2_nxt = w_idx2_new;
                  w_win_nxt  = r_win_cnt - WW'(1);
                  if (r_win_cnt == WW'(1)) begin
                     if (w_max2_new >= THRESH) begin
                        w_lock_nxt        = 1'b1;
                        w_lock_strobe_nxt = 1'b1;
                        w_peak_idx_nxt    = w_idx2_new;
                        w_state_nxt       = StLocked;
                     end else begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = StFail;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state       <= StIdle;
         r_sample_cnt  <= '0;
         r_max1        <= '0;
         r_idx1        <= '0;
         r_max2        <= '0;
         r_idx2        <= '0;
         r_ref_cnt     <= '0;
         r_win_cnt     <= '0;
         r_lock        <= 1'b0;
         r_lock_strobe <= 1'b0;
         r_fail        <= 1'b0;
         r_peak_idx    <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_sample_cnt  <= w_cnt_nxt;
         r_max1        <= w_max1_nxt;
         r_idx1        <= w_idx1_nxt;
         r_max2        <= w_max2_nxt;
         r_idx2        <= w_idx2_nxt;
         r_ref_cnt     <= w_ref_nxt;
         r_win_cnt     <= w_win_nxt;
         r_lock        <= w_lock_nxt;
         r_lock_strobe <= w_lock_strobe_nxt;
         r_fail        <= w_fail_nxt;
         r_peak_idx    <= w_peak_idx_nxt;
      end
   end

endmodule

// File: tb/tb_lsync_peak_ctrl.sv
// Bench for lsync_peak_ctrl: directed and randomized sample streams vs. a rule-level model.
module tb_lsync_peak_ctrl;
   import lsync_pkg::*;

   logic              CLK = 1'b0;
   logic              RST_n = 1'b0;
   logic              sync_start = 1'b0;
   logic              corr_strobe = 1'b0;
   logic signed [6:0] I_corr = '0;
   logic signed [6:0] Q_corr = '0;
   logic              corr_enable, corr_s_rst, lock, lock_strobe, fail, busy;
   logic [9:0]        peak_idx;

   logic signed [6:0] t_i = '0;
   logic signed [6:0] t_q = '0;
   logic [7:0]        t_m;

   int n_checks = 0;
   int n_fail   = 0;

   int si [0:399];
   int sq [0:399];
   int sm [0:399];
   int e_lock, e_idx, e_dec;

   always #5 CLK = ~CLK;

   lsync_peak_ctrl dut (
      .CLK         (CLK),
      .RST_n       (RST_n),
      .sync_start  (sync_start),
      .corr_strobe (corr_strobe),
      .I_corr      (I_corr),
      .Q_corr      (Q_corr),
      .corr_enable (corr_enable),
      .corr_s_rst  (corr_s_rst),
      .lock        (lock),
      .lock_strobe (lock_strobe),
      .fail        (fail),
      .peak_idx    (peak_idx),
      .busy        (busy)
   );

   lsync_metric u_metric_chk (
      .i_i_corr (t_i),
      .i_q_corr (t_q),
      .o_metric (t_m)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int absv(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic scene_zero();
      for (int k = 0; k < 400; k++) begin
         si[k] = 0;
         sq[k] = 0;
      end
   endtask

   // Background noise: |I|,|Q| <= 19 keeps every metric below 40.
   task automatic scene_noise();
      for (int k = 0; k < 400; k++) begin
         si[k] = int'($urandom_range(38)) - 19;
         sq[k] = int'($urandom_range(38)) - 19;
      end
   endtask

   task automatic put(input int k, input int i, input int q);
      si[k] = i;
      sq[k] = q;
   endtask

   // Random component with magnitude 20..64 inside the 7-bit signed range.
   function automatic int rmag();
      int mag;
      mag = int'($urandom_range(20, 64));
      if ($urandom_range(1) == 1) return -mag;
      return (mag > 63) ? 63 : mag;
   endfunction

   // Rule-level reference: first crossing, refine over the next REFINE_LEN samples,
   // then best sample >= 40 in idx1+64 +/- 2; e_dec is the deciding sample index.
   task automatic model();
      int first, mx, best, bm, w0;
      for (int k = 0; k < 400; k++) sm[k] = absv(si[k]) + absv(sq[k]);
      first = -1;
      for (int k = 0; k < 320; k++) begin
         if (first < 0 && sm[k] >= 40) first = k;
      end
      if (first < 0) begin
         e_lock = 0;
         e_idx  = 0;
         e_dec  = 319;
         return;
      end
      e_idx = first;
      mx    = sm[first];
      for (int k = first + 1; k <= first + 4; k++) begin
         if (sm[k] > mx) begin
            mx    = sm[k];
            e_idx = k;
         end
      end
      w0   = e_idx + 64 - 2;
      best = -1;
      bm   = 0;
      for (int k = w0; k <= w0 + 4; k++) begin
         if (sm[k] >= 40 && sm[k] > bm) begin
            bm   = sm[k];
            best = k;
         end
      end
      e_dec  = w0 + 4;
      e_lock = (best >= 0) ? 1 : 0;
      e_idx  = best;
   endtask

   task automatic strobe(input int k, input int gap);
      repeat (gap) @(negedge CLK);
      corr_strobe = 1'b1;
      I_corr      = 7'(si[k]);
      Q_corr      = 7'(sq[k]);
      @(negedge CLK);
      corr_strobe = 1'b0;
   endtask

   // Restart with a competing strobe on the same edge and another during CLEAR.
   task automatic pulse_start();
      @(negedge CLK);
      sync_start  = 1'b1;
      corr_strobe = 1'b1;
      I_corr      = -7'sd64;
      Q_corr      = -7'sd64;
      @(negedge CLK);
      sync_start  = 1'b0;
      check("clear_s_rst", 32'(corr_s_rst), 32'd1);
      check("clear_enable", 32'(corr_enable), 32'd0);
      check("clear_busy", 32'(busy), 32'd1);
      check("clear_lock", 32'(lock), 32'd0);
      check("clear_fail", 32'(fail), 32'd0);
      check("clear_peak_idx", 32'(peak_idx), 32'd0);
      @(negedge CLK);
      corr_strobe = 1'b0;
      check("search_s_rst", 32'(corr_s_rst), 32'd0);
      check("search_enable", 32'(corr_enable), 32'd1);
   endtask

   task automatic run_body(input string name);
      for (int k = 0; k <= e_dec; k++) begin
         strobe(k, int'($urandom_range(2)));
         if (k == e_dec - 1) begin
            check({name, "_pre_lock"}, 32'(lock), 32'd0);
            check({name, "_pre_fail"}, 32'(fail), 32'd0);
            check({name, "_pre_busy"}, 32'(busy), 32'd1);
         end
      end
      check({name, "_lock_strobe"}, 32'(lock_strobe), 32'(e_lock));
      check({name, "_lock"}, 32'(lock), 32'(e_lock));
      check({name, "_fail"}, 32'(fail), 32'(1 - e_lock));
      check({name, "_enable_off"}, 32'(corr_enable), 32'd0);
      check({name, "_busy_off"}, 32'(busy), 32'd0);
      if (e_lock == 1) check({name, "_peak_idx"}, 32'(peak_idx), 32'(e_idx));
      @(negedge CLK);
      check({name, "_strobe_1cyc"}, 32'(lock_strobe), 32'd0);
      check({name, "_lock_held"}, 32'(lock), 32'(e_lock));
   endtask

   task automatic run_trial(input string name);
      model();
      pulse_start();
      run_body(name);
   endtask

   initial begin
      int p, r;

      // Reset state
      #23;
      check("rst_enable", 32'(corr_enable), 32'd0);
      check("rst_s_rst", 32'(corr_s_rst), 32'd0);
      check("rst_lock", 32'(lock), 32'd0);
      check("rst_lock_strobe", 32'(lock_strobe), 32'd0);
      check("rst_fail", 32'(fail), 32'd0);
      check("rst_peak_idx", 32'(peak_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge CLK);
      RST_n = 1'b1;
      @(negedge CLK);
      check("idle_busy", 32'(busy), 32'd0);

      // Scorer on extremes and random pairs
      t_i = -7'sd64; t_q = -7'sd64; #1;
      check("metric_min_min", 32'(t_m), 32'd128);
      t_i = 7'sd63;  t_q = -7'sd64; #1;
      check("metric_max_min", 32'(t_m), 32'd127);
      t_i = 7'sd0;   t_q = 7'sd0;   #1;
      check("metric_zero", 32'(t_m), 32'd0);
      for (int n = 0; n < 16; n++) begin
         int a, b;
         a = int'($urandom_range(127)) - 64;
         b = int'($urandom_range(127)) - 64;
         t_i = 7'(a);
         t_q = 7'(b);
         #1;
         check("metric_rand", 32'(t_m), 32'(absv(a) + absv(b)));
      end

      // Two clean peaks 64 apart
      scene_zero();
      put(20, 32, 16);
      put(84, 32, 16);
      run_trial("basic");
      strobe(20, 0);
      strobe(84, 0);
      check("locked_ignores_lock", 32'(lock), 32'd1);
      check("locked_ignores_idx", 32'(peak_idx), 32'd84);
      check("locked_ignores_busy", 32'(busy), 32'd0);

      // Refinement moves peak 1
      scene_zero();
      put(10, 20, 20);
      put(12, 30, 30);
      put(76, 25, 25);
      run_trial("refine");

      // Second peak outside the window
      scene_zero();
      put(20, 32, 16);
      put(90, 32, 16);
      run_trial("miss");

      // Nothing crosses threshold
      scene_noise();
      run_trial("timeout");

      // Extreme components, strict-greater tie handling in the window
      scene_noise();
      put(30, -64, -64);
      put(93, -50, 50);
      put(95, -64, -64);
      put(96, -64, -64);
      run_trial("extreme");

      // Ties in refine and window keep the earliest sample
      scene_zero();
      put(5, 20, 20);
      put(7, 20, 20);
      put(69, 30, -30);
      put(70, -30, 30);
      run_trial("ties");

      // Restart from inside SEARCH2, then a full run from sample 0
      scene_zero();
      put(20, 32, 16);
      put(84, 32, 16);
      model();
      pulse_start();
      for (int k = 0; k <= 83; k++) strobe(k, 0);
      check("abort_busy", 32'(busy), 32'd1);
      pulse_start();
      run_body("after_abort");

      // Asynchronous reset in the middle of REFINE
      scene_zero();
      put(40, 40, 20);
      model();
      pulse_start();
      for (int k = 0; k <= 42; k++) strobe(k, 0);
      #2;
      RST_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_enable", 32'(corr_enable), 32'd0);
      check("arst_s_rst", 32'(corr_s_rst), 32'd0);
      check("arst_lock", 32'(lock), 32'd0);
      check("arst_fail", 32'(fail), 32'd0);
      @(negedge CLK);
      RST_n = 1'b1;
      @(negedge CLK);
      check("arst_no_clear", 32'(corr_s_rst), 32'd0);

      // Randomized streams
      for (int t = 0; t < 6; t++) begin
         scene_noise();
         p = int'($urandom_range(250));
         put(p, rmag(), rmag());
         for (int k = p + 1; k <= p + 4; k++) begin
            if ($urandom_range(1) == 1) put(k, rmag(), rmag());
         end
         for (int k = p + 58; k <= p + 72; k++) begin
            r = int'($urandom_range(3));
            if (r == 0) put(k, rmag(), rmag());
            else if (r == 1) put(k, 20, int'($urandom_range(10, 19)));
         end
         run_trial("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
